// File: rtl/board_state_regs.sv
// Board-state register file: validates one move per cycle, stores 2-bit cell codes,
// and tracks move count, turn and board-full. Optional undo LIFO under `BOARD_UNDO_EN`.
module board_state_regs #(
  parameter int CELLS        = 16,
  parameter int FIRST_PLAYER = 0,
  parameter int ENFORCE_TURN = 1,
  localparam int IW          = $clog2(CELLS),
  localparam int CW          = IW + 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 inhibit,
  input  logic                 move_valid,
  input  logic                 move_side,
  input  logic [IW-1:0]        move_idx,
  input  logic                 undo,
  output logic [2*CELLS-1:0]   board,
  output logic                 move_accept,
  output logic                 move_reject,
  output logic [1:0]           reject_code,
  output logic [CW-1:0]        move_count,
  output logic                 turn,
  output logic                 board_full
);

  typedef enum logic [1:0] {
    CELL_EMPTY    = 2'b00,
    CELL_PLAYER   = 2'b01,
    CELL_COMPUTER = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    REJ_NONE     = 2'b00,
    REJ_OCCUPIED = 2'b01,
    REJ_RANGE    = 2'b10,
    REJ_TURN     = 2'b11
  } rej_t;

  localparam logic START_SIDE = 1'(FIRST_PLAYER);

  cell_t         cells_q [CELLS];
  cell_t         cells_d [CELLS];
  logic [CW-1:0] count_q, count_d;
  logic          turn_q, turn_d;
  logic          accept_q, accept_d;
  logic          reject_q, reject_d;
  rej_t          code_q, code_d;

  logic          push;
  logic          undo_fire;
  logic [IW-1:0] top_idx;
  logic          top_side;
  logic          turn_bad;
  logic          in_range;
  logic          target_busy;

`ifdef BOARD_UNDO_EN
  // The stack depth always equals move_count, so the count doubles as stack pointer.
  logic          stack_side [CELLS];
  logic [IW-1:0] stack_idx  [CELLS];
  logic [IW-1:0] top_ptr;

  assign top_ptr   = IW'(count_q - CW'(1));
  assign top_idx   = stack_idx[top_ptr];
  assign top_side  = stack_side[top_ptr];
  assign undo_fire = undo && !inhibit && (count_q != '0);

  // NOTE: stack storage has no reset; entries above the count are never read,
  // so resetting them would only cost flops.
  always_ff @(posedge clock) begin
    if (push) begin
      stack_side[IW'(count_q)] <= move_side;
      stack_idx[IW'(count_q)]  <= move_idx;
    end
  end
`else
  logic unused_undo_path;

  assign top_idx          = '0;
  assign top_side         = 1'b0;
  assign undo_fire        = 1'b0;
  assign unused_undo_path = ^{undo, push};
`endif

  assign turn_bad = inhibit || ((ENFORCE_TURN != 0) && (move_side != turn_q));
  assign in_range = ({1'b0, move_idx} < CW'(CELLS));

  always_comb begin
    target_busy = 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      if (move_idx == IW'(i)) target_busy = (cells_q[i] != CELL_EMPTY);
    end
  end

  // NOTE: every next-state signal takes its hold value first, so no path
  // through the priority chain leaves one unassigned and infers a latch.
  always_comb begin
    cells_d  = cells_q;
    count_d  = count_q;
    turn_d   = turn_q;
    accept_d = 1'b0;
    reject_d = 1'b0;
    code_d   = code_q;
    push     = 1'b0;

    if (clear) begin
      for (int i = 0; i < CELLS; i++) cells_d[i] = CELL_EMPTY;
      count_d = '0;
      turn_d  = START_SIDE;
      code_d  = REJ_NONE;
      if (move_valid) begin
        reject_d = 1'b1;
        code_d   = REJ_TURN;
      end
    end else if (undo_fire) begin
      for (int i = 0; i < CELLS; i++) begin
        if (top_idx == IW'(i)) cells_d[i] = CELL_EMPTY;
      end
      count_d  = count_q - CW'(1);
      turn_d   = top_side;
      accept_d = 1'b1;
      if (move_valid) begin
        reject_d = 1'b1;
        code_d   = REJ_TURN;
      end
    end else if (move_valid) begin
      if (turn_bad) begin
        reject_d = 1'b1;
        code_d   = REJ_TURN;
      end else if (!in_range) begin
        reject_d = 1'b1;
        code_d   = REJ_RANGE;
      end else if (target_busy) begin
        // A full board lands here too: every cell is occupied.
        reject_d = 1'b1;
        code_d   = REJ_OCCUPIED;
      end else begin
        for (int i = 0; i < CELLS; i++) begin
          if (move_idx == IW'(i)) cells_d[i] = move_side ? CELL_COMPUTER : CELL_PLAYER;
        end
        count_d  = count_q + CW'(1);
        turn_d   = ~move_side;
        accept_d = 1'b1;
        push     = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CELLS; i++) cells_q[i] <= CELL_EMPTY;
      count_q  <= '0;
      turn_q   <= START_SIDE;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
      code_q   <= REJ_NONE;
    end else begin
      cells_q  <= cells_d;
      count_q  <= count_d;
      turn_q   <= turn_d;
      accept_q <= accept_d;
      reject_q <= reject_d;
      code_q   <= code_d;
    end
  end

  always_comb begin
    for (int i = 0; i < CELLS; i++) board[2*i +: 2] = cells_q[i];
  end

  assign move_accept = accept_q;
  assign move_reject = reject_q;
  assign reject_code = code_q;
  assign move_count  = count_q;
  assign turn        = turn_q;
  assign board_full  = (count_q == CW'(CELLS));

endmodule

// File: tb/tb_board_state_regs.sv
// Directed bench for board_state_regs: a 16-cell instance for the main scenarios and a
// 9-cell instance for the out-of-range check. Undo expectations follow `BOARD_UNDO_EN`.
module tb_board_state_regs;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0, inhibit = 1'b0, move_valid = 1'b0, move_side = 1'b0, undo = 1'b0;
  logic [3:0]  move_idx = '0;
  logic [31:0] board;
  logic        move_accept, move_reject, turn, board_full;
  logic [1:0]  reject_code;
  logic [4:0]  move_count;

  logic        move_valid9 = 1'b0;
  logic [3:0]  move_idx9 = '0;
  logic [17:0] board9;
  logic        accept9, reject9, turn9, full9;
  logic [1:0]  code9;
  logic [4:0]  count9;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  board_state_regs #(.CELLS(16), .FIRST_PLAYER(0), .ENFORCE_TURN(1)) dut (
    .clock(clock), .reset_n(reset_n), .clear(clear), .inhibit(inhibit),
    .move_valid(move_valid), .move_side(move_side), .move_idx(move_idx), .undo(undo),
    .board(board), .move_accept(move_accept), .move_reject(move_reject),
    .reject_code(reject_code), .move_count(move_count), .turn(turn), .board_full(board_full)
  );

  board_state_regs #(.CELLS(9), .FIRST_PLAYER(0), .ENFORCE_TURN(1)) dut9 (
    .clock(clock), .reset_n(reset_n), .clear(1'b0), .inhibit(1'b0),
    .move_valid(move_valid9), .move_side(1'b0), .move_idx(move_idx9), .undo(1'b0),
    .board(board9), .move_accept(accept9), .move_reject(reject9),
    .reject_code(code9), .move_count(count9), .turn(turn9), .board_full(full9)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic mv(input logic side, input logic [3:0] idx);
    move_valid = 1'b1;
    move_side  = side;
    move_idx   = idx;
    step();
    move_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    step(); step();
    reset_n = 1'b1;
    step();
    checks++; if (board !== 32'h0) begin errors++; $display("FAIL reset_board: got %h expected %h", board, 32'h0); end
    checks++; if (move_count !== 5'd0 || turn !== 1'b0 || board_full !== 1'b0) begin errors++;
      $display("FAIL reset_state: got count=%0d turn=%0b full=%0b expected 0/0/0", move_count, turn, board_full); end
    checks++; if (reject_code !== 2'b00 || move_accept !== 1'b0 || move_reject !== 1'b0) begin errors++;
      $display("FAIL reset_pulses: got code=%b acc=%b rej=%b expected 00/0/0", reject_code, move_accept, move_reject); end
    for (int i = 0; i < 5; i++) mv(1'(i % 2), 4'(i));
    checks++; if (move_count !== 5'd5 || board !== 32'h0000_0199) begin errors++;
      $display("FAIL midgame_setup: got count=%0d board=%h expected 5/00000199", move_count, board); end
    reset_n = 1'b0;
    #1;
    checks++; if (board !== 32'h0 || move_count !== 5'd0 || turn !== 1'b0) begin errors++;
      $display("FAIL async_reset: got board=%h count=%0d turn=%0b expected 0/0/0", board, move_count, turn); end
    checks++; if (move_accept !== 1'b0 || move_reject !== 1'b0) begin errors++;
      $display("FAIL async_reset_pulse: got acc=%b rej=%b expected 0/0", move_accept, move_reject); end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic_moves();
    mv(1'b0, 4'd5);
    checks++; if (move_accept !== 1'b1 || turn !== 1'b1 || move_count !== 5'd1) begin errors++;
      $display("FAIL player_move: got acc=%b turn=%b count=%0d expected 1/1/1", move_accept, turn, move_count); end
    mv(1'b1, 4'd6);
    checks++; if (board !== 32'h0000_2400) begin errors++; $display("FAIL two_moves_board: got %h expected %h", board, 32'h0000_2400); end
    checks++; if (move_count !== 5'd2 || turn !== 1'b0 || move_accept !== 1'b1) begin errors++;
      $display("FAIL two_moves_state: got count=%0d turn=%b acc=%b expected 2/0/1", move_count, turn, move_accept); end
  endtask

  task automatic test_rejects();
    mv(1'b0, 4'd5);
    checks++; if (move_reject !== 1'b1 || move_accept !== 1'b0 || reject_code !== 2'b01) begin errors++;
      $display("FAIL occupied: got rej=%b acc=%b code=%b expected 1/0/01", move_reject, move_accept, reject_code); end
    mv(1'b1, 4'd3);
    checks++; if (move_reject !== 1'b1 || reject_code !== 2'b11) begin errors++;
      $display("FAIL wrong_turn: got rej=%b code=%b expected 1/11", move_reject, reject_code); end
    checks++; if (board !== 32'h0000_2400 || move_count !== 5'd2 || turn !== 1'b0) begin errors++;
      $display("FAIL reject_no_change: got board=%h count=%0d turn=%b expected 00002400/2/0", board, move_count, turn); end
    step();
    checks++; if (move_reject !== 1'b0 || reject_code !== 2'b11) begin errors++;
      $display("FAIL code_hold: got rej=%b code=%b expected 0/11", move_reject, reject_code); end
    move_valid9 = 1'b1;
    move_idx9   = 4'd12;
    step();
    move_valid9 = 1'b0;
    checks++; if (reject9 !== 1'b1 || code9 !== 2'b10 || count9 !== 5'd0 || board9 !== 18'h0) begin errors++;
      $display("FAIL out_of_range: got rej=%b code=%b count=%0d board=%h expected 1/10/0/0", reject9, code9, count9, board9); end
  endtask

  task automatic test_fill_back_to_back();
    do_clear();
    checks++; if (board !== 32'h0 || move_count !== 5'd0 || reject_code !== 2'b00) begin errors++;
      $display("FAIL clear_state: got board=%h count=%0d code=%b expected 0/0/00", board, move_count, reject_code); end
    checks++; if (move_accept !== 1'b0 || move_reject !== 1'b0) begin errors++;
      $display("FAIL clear_pulse: got acc=%b rej=%b expected 0/0", move_accept, move_reject); end
    for (int i = 0; i < 16; i++) begin
      mv(1'(i % 2), 4'(i));
      if (i == 14) begin
        checks++; if (board_full !== 1'b0 || move_count !== 5'd15) begin errors++;
          $display("FAIL almost_full: got full=%b count=%0d expected 0/15", board_full, move_count); end
      end
    end
    checks++; if (board !== 32'h9999_9999 || board_full !== 1'b1 || move_count !== 5'd16) begin errors++;
      $display("FAIL full_board: got board=%h full=%b count=%0d expected 99999999/1/16", board, board_full, move_count); end
    mv(1'b0, 4'd0);
    checks++; if (move_reject !== 1'b1 || reject_code !== 2'b01 || move_count !== 5'd16) begin errors++;
      $display("FAIL full_reject: got rej=%b code=%b count=%0d expected 1/01/16", move_reject, reject_code, move_count); end
    do_clear();
    checks++; if (move_count !== 5'd0 || turn !== 1'b0 || board_full !== 1'b0 || board !== 32'h0) begin errors++;
      $display("FAIL clear_after_full: got count=%0d turn=%b full=%b board=%h expected 0/0/0/0", move_count, turn, board_full, board); end
  endtask

  task automatic test_inhibit_clear();
    inhibit = 1'b1;
    mv(1'b0, 4'd2);
    inhibit = 1'b0;
    checks++; if (move_reject !== 1'b1 || reject_code !== 2'b11 || board !== 32'h0 || move_count !== 5'd0) begin errors++;
      $display("FAIL inhibit: got rej=%b code=%b board=%h count=%0d expected 1/11/0/0", move_reject, reject_code, board, move_count); end
    mv(1'b0, 4'd2);
    checks++; if (move_accept !== 1'b1 || board !== 32'h0000_0010) begin errors++;
      $display("FAIL after_inhibit: got acc=%b board=%h expected 1/00000010", move_accept, board); end
    clear = 1'b1;
    mv(1'b1, 4'd4);
    clear = 1'b0;
    checks++; if (board !== 32'h0 || move_reject !== 1'b1 || reject_code !== 2'b11 || move_accept !== 1'b0) begin errors++;
      $display("FAIL clear_with_move: got board=%h rej=%b code=%b acc=%b expected 0/1/11/0", board, move_reject, reject_code, move_accept); end
    checks++; if (move_count !== 5'd0 || turn !== 1'b0) begin errors++;
      $display("FAIL clear_with_move_state: got count=%0d turn=%b expected 0/0", move_count, turn); end
  endtask

  task automatic test_undo();
    mv(1'b0, 4'd3);
    mv(1'b1, 4'd7);
    checks++; if (board !== 32'h0000_8040 || move_count !== 5'd2) begin errors++;
      $display("FAIL undo_setup: got board=%h count=%0d expected 00008040/2", board, move_count); end
    undo = 1'b1; inhibit = 1'b1;
    step();
    undo = 1'b0; inhibit = 1'b0;
    checks++; if (move_accept !== 1'b0 || move_reject !== 1'b0 || board !== 32'h0000_8040) begin errors++;
      $display("FAIL undo_inhibited: got acc=%b rej=%b board=%h expected 0/0/00008040", move_accept, move_reject, board); end
    undo = 1'b1;
    step();
    undo = 1'b0;
`ifdef BOARD_UNDO_EN
    checks++; if (board !== 32'h0000_0040 || move_count !== 5'd1 || turn !== 1'b1) begin errors++;
      $display("FAIL undo1: got board=%h count=%0d turn=%b expected 00000040/1/1", board, move_count, turn); end
    checks++; if (move_accept !== 1'b1 || reject_code !== 2'b11) begin errors++;
      $display("FAIL undo1_pulse: got acc=%b code=%b expected 1/11", move_accept, reject_code); end
    undo = 1'b1;
    step();
    undo = 1'b0;
    checks++; if (board !== 32'h0 || move_count !== 5'd0 || turn !== 1'b0 || move_accept !== 1'b1) begin errors++;
      $display("FAIL undo2: got board=%h count=%0d turn=%b acc=%b expected 0/0/0/1", board, move_count, turn, move_accept); end
    undo = 1'b1;
    step();
    undo = 1'b0;
    checks++; if (move_accept !== 1'b0 || move_reject !== 1'b0 || move_count !== 5'd0) begin errors++;
      $display("FAIL undo_empty: got acc=%b rej=%b count=%0d expected 0/0/0", move_accept, move_reject, move_count); end
`else
    checks++; if (board !== 32'h0000_8040 || move_count !== 5'd2 || turn !== 1'b0 || move_accept !== 1'b0) begin errors++;
      $display("FAIL undo_ignored: got board=%h count=%0d turn=%b acc=%b expected 00008040/2/0/0", board, move_count, turn, move_accept); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_moves();
    test_rejects();
    test_fill_back_to_back();
    test_inhibit_clear();
    test_undo();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
